// File: rtl/my_isa_pkg.sv
// Shared ISA definitions for the 16-bit core: instruction class nibbles,
// ALU function codes, the symbolic op enum and the HALT word.
package my_isa_pkg;

  localparam logic [3:0] CLS_ALU  = 4'b0101;
  localparam logic [3:0] CLS_ADD  = 4'b1110;
  localparam logic [3:0] CLS_ADDI = 4'b1100;

  localparam logic [3:0] FN_NOT = 4'b0000;
  localparam logic [3:0] FN_OR  = 4'b0001;
  localparam logic [3:0] FN_XOR = 4'b0010;
  localparam logic [3:0] FN_AND = 4'b0011;
  localparam logic [3:0] FN_FAS = 4'b0100;
  localparam logic [3:0] FN_SUB = 4'b1000;

  localparam logic [15:0] HALT_WORD = 16'h0000;

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_AND  = 3'd3,
    OP_FAS  = 3'd4,
    OP_SUB  = 3'd5,
    OP_ADD  = 3'd6,
    OP_ADDI = 3'd7
  } op_e;

endpackage

// File: rtl/my_encode_word.sv
// Pure combinational packer: symbolic op plus register/immediate fields
// into one 16-bit instruction word.
module my_encode_word
  import my_isa_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic [7:0]  imm,
  output logic [15:0] word
);

  // NOTE: every output of an always_comb gets a default first so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    word = HALT_WORD;
    unique case (op_e'(op))
      OP_NOT:  word = {CLS_ALU, ra, rb, FN_NOT};
      OP_OR:   word = {CLS_ALU, ra, rb, FN_OR};
      OP_XOR:  word = {CLS_ALU, ra, rb, FN_XOR};
      OP_AND:  word = {CLS_ALU, ra, rb, FN_AND};
      OP_FAS:  word = {CLS_ALU, ra, rb, FN_FAS};
      OP_SUB:  word = {CLS_ALU, ra, rb, FN_SUB};
      OP_ADD:  word = {CLS_ADD, ra, rb, 4'b0000};
      OP_ADDI: word = {CLS_ADDI, ra, imm};
      default: word = HALT_WORD;
    endcase
  end

endmodule

// File: rtl/my_encoder.sv
// Instruction encoder / program loader: packs handshaked ops into words and
// writes them to consecutive addresses from BASE. Optional MY_ENCODER_HALT_EN
// appends a HALT word after the last op.
module my_encoder
  import my_isa_pkg::*;
#(
  parameter int            AW   = 8,
  parameter logic [AW-1:0] BASE = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [3:0]    in_ra,
  input  logic [3:0]    in_rb,
  input  logic [7:0]    in_imm,
  input  logic          in_last,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALT_WR = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e        state, next_state;
  logic [AW-1:0] cnt;
  logic [15:0]   word;
  logic          xfer, halt_wr, start_run, err_set;
  logic          cnt_full;

  my_encode_word u_encode_word (
    .op   (in_op),
    .ra   (in_ra),
    .rb   (in_rb),
    .imm  (in_imm),
    .word (word)
  );

  // The counter points at the address the next write will use.
  assign cnt_full = &cnt;

  always_comb begin
    next_state = state;
    xfer       = 1'b0;
    halt_wr    = 1'b0;
    start_run  = 1'b0;
    err_set    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_run  = 1'b1;
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          xfer = 1'b1;
          if (cnt_full) begin
            // Last address consumed: the run ends here whatever in_last says.
            next_state = ST_DONE;
`ifdef MY_ENCODER_HALT_EN
            err_set    = 1'b1;
`else
            err_set    = ~in_last;
`endif
          end else if (in_last) begin
`ifdef MY_ENCODER_HALT_EN
            next_state = ST_HALT_WR;
`else
            next_state = ST_DONE;
`endif
          end
        end
      end
`ifdef MY_ENCODER_HALT_EN
      ST_HALT_WR: begin
        halt_wr    = 1'b1;
        next_state = ST_DONE;
      end
`endif
      default: next_state = ST_IDLE;
    endcase
  end

  assign in_ready = (state == ST_RUN);
  assign busy     = (state == ST_RUN) || (state == ST_HALT_WR);
  assign done     = (state == ST_DONE);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= BASE;
      wr_en   <= 1'b0;
      wr_addr <= BASE;
      wr_data <= '0;
      err     <= 1'b0;
    end else begin
      wr_en <= xfer || halt_wr;
      if (xfer || halt_wr) begin
        wr_addr <= cnt;
        wr_data <= halt_wr ? HALT_WORD : word;
        cnt     <= cnt + AW'(1);
      end
      if (start_run) begin
        cnt <= BASE;
        err <= 1'b0;
      end else if (err_set) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_my_encoder.sv
// Self-checking bench for my_encoder: directed scenarios plus randomized
// programs, checked every cycle against a transaction-level reference model.
module tb_my_encoder;

  localparam int            AW   = 3;
  localparam logic [AW-1:0] BASE = '0;
  localparam int            MAXA = (1 << AW) - 1;
`ifdef MY_ENCODER_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = '0;
  logic [3:0]    in_ra = '0;
  logic [3:0]    in_rb = '0;
  logic [7:0]    in_imm = '0;
  logic          in_last = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  my_encoder #(.AW(AW), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm), .in_last(in_last),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference encoding straight from the instruction format table.
  function automatic logic [15:0] ref_word(input int op, input int ra, input int rb, input int imm);
    logic [3:0] a, b, fn;
    logic [7:0] i8;
    a  = ra[3:0];
    b  = rb[3:0];
    i8 = imm[7:0];
    fn = (op == 5) ? 4'h8 : op[3:0];
    if (op == 7) return {4'hC, a, i8};
    if (op == 6) return {4'hE, a, b, 4'h0};
    return {4'h5, a, b, fn};
  endfunction

  // Transaction-level model: phase of the load run plus the next address.
  typedef enum int {M_IDLE, M_RUN, M_HALT, M_DONE} mphase_e;
  mphase_e     m_phase = M_IDLE;
  int          m_next  = 0;
  bit          model_ok = 1'b0;
  logic        exp_wr_en = 1'b0;
  int          exp_addr = 0;
  logic [15:0] exp_data = '0;
  logic        exp_err = 1'b0;

  always @(posedge clk) begin
    model_ok  = 1'b1;
    exp_wr_en = 1'b0;
    if (rst) begin
      m_phase  = M_IDLE;
      m_next   = int'(BASE);
      exp_addr = int'(BASE);
      exp_data = '0;
      exp_err  = 1'b0;
    end else begin
      case (m_phase)
        M_IDLE, M_DONE: if (start) begin
          m_phase = M_RUN;
          m_next  = int'(BASE);
          exp_err = 1'b0;
        end
        M_RUN: if (in_valid) begin
          exp_wr_en = 1'b1;
          exp_addr  = m_next;
          exp_data  = ref_word(int'(in_op), int'(in_ra), int'(in_rb), int'(in_imm));
          if (m_next == MAXA) begin
            m_phase = M_DONE;
            exp_err = HALT_EN ? 1'b1 : !in_last;
          end else if (in_last) begin
            m_phase = HALT_EN ? M_HALT : M_DONE;
          end
          m_next = m_next + 1;
        end
        M_HALT: begin
          exp_wr_en = 1'b1;
          exp_addr  = m_next;
          exp_data  = 16'h0000;
          m_next    = m_next + 1;
          m_phase   = M_DONE;
        end
        default: m_phase = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("in_ready", 32'(in_ready), 32'(m_phase == M_RUN));
      check("busy",     32'(busy),     32'(m_phase == M_RUN || m_phase == M_HALT));
      check("done",     32'(done),     32'(m_phase == M_DONE));
      check("err",      32'(err),      32'(exp_err));
      check("wr_en",    32'(wr_en),    32'(exp_wr_en));
      check("wr_addr",  32'(wr_addr),  32'(exp_addr));
      if (wr_en) check("wr_data", 32'(wr_data), 32'(exp_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Presents one op and waits up to budget cycles for it to be taken.
  // in_valid is left high so callers can chain ops back-to-back.
  task automatic send_op(input int op, input int ra, input int rb, input int imm,
                         input bit last, input int budget, output bit accepted,
                         output logic [AW-1:0] got_addr, output logic [15:0] got_data);
    in_valid = 1'b1;
    in_op    = op[2:0];
    in_ra    = ra[3:0];
    in_rb    = rb[3:0];
    in_imm   = imm[7:0];
    in_last  = last;
    accepted = 1'b0;
    for (int i = 0; i < budget && !accepted; i++) begin
      if (in_ready) accepted = 1'b1;
      tick();
      start = 1'b0;
    end
    got_addr = wr_addr;
    got_data = wr_data;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !done; i++) tick();
    check("done_reached", 32'(done), 32'd1);
  endtask

  initial begin : stim
    bit          acc;
    logic [AW-1:0] a;
    logic [15:0] d;
    logic [AW-1:0] held;

    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wr_en",    32'(wr_en),    32'd0);
    check("rst_wr_addr",  32'(wr_addr),  32'(BASE));
    check("rst_wr_data",  32'(wr_data),  32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_err",      32'(err),      32'd0);

    // Single SUB marked last.
    pulse_start();
    send_op(5, 1, 2, $urandom_range(0, 255), 1'b1, 3, acc, a, d);
    check("sub_acc",  32'(acc),   32'd1);
    check("sub_wren", 32'(wr_en), 32'd1);
    check("sub_addr", 32'(a),     32'd0);
    check("sub_data", 32'(d),     32'h5128);
    in_valid = 1'b0;
    wait_done();
    check("sub_busy", 32'(busy), 32'd0);
    check("sub_err",  32'(err),  32'd0);

    // Back-to-back ADD, ADDI, AND(last): one word per cycle.
    pulse_start();
    send_op(6, 3, 4, $urandom_range(0, 255), 1'b0, 1, acc, a, d);
    check("b2b0_acc", 32'(acc), 32'd1);
    check("b2b0_addr", 32'(a), 32'd0);
    check("b2b0_data", 32'(d), 32'hE340);
    send_op(7, 2, $urandom_range(0, 15), 8'hFF, 1'b0, 1, acc, a, d);
    check("b2b1_acc", 32'(acc), 32'd1);
    check("b2b1_addr", 32'(a), 32'd1);
    check("b2b1_data", 32'(d), 32'hC2FF);
    send_op(3, 0, 0, $urandom_range(0, 255), 1'b1, 1, acc, a, d);
    check("b2b2_acc", 32'(acc), 32'd1);
    check("b2b2_addr", 32'(a), 32'd2);
    check("b2b2_data", 32'(d), 32'h5003);
    in_valid = 1'b0;
    wait_done();

    // Bubble of three idle cycles mid-run.
    pulse_start();
    send_op(1, 7, 9, 0, 1'b0, 3, acc, a, d);
    held = a;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bubble_wren", 32'(wr_en), 32'd0);
      check("bubble_addr", 32'(wr_addr), 32'(held));
    end
    send_op(2, 4, 4, 0, 1'b1, 3, acc, a, d);
    check("bubble_next_addr", 32'(a), 32'd1);
    in_valid = 1'b0;
    wait_done();

    // Fill the whole memory without last: overflow sets err and ends the run.
    pulse_start();
    for (int k = 0; k <= MAXA; k++) begin
      send_op(0, k, k, 0, 1'b0, 1, acc, a, d);
      check("fill_acc",  32'(acc), 32'd1);
      check("fill_addr", 32'(a),   32'(k));
    end
    check("ovf_ready", 32'(in_ready), 32'd0);
    check("ovf_done",  32'(done),     32'd1);
    check("ovf_err",   32'(err),      32'd1);
    send_op(6, 1, 1, 0, 1'b0, 3, acc, a, d);
    check("ovf_extra_rejected", 32'(acc), 32'd0);

    // Start coincident with a valid op: no transfer that cycle; err cleared.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("startv_wren",  32'(wr_en),    32'd0);
    check("startv_err",   32'(err),      32'd0);
    check("startv_done",  32'(done),     32'd0);
    check("startv_ready", 32'(in_ready), 32'd1);
    send_op(0, 5, 0, 0, 1'b1, 3, acc, a, d);
    check("not_addr", 32'(a), 32'd0);
    check("not_data", 32'(d), 32'h5500);
    in_valid = 1'b0;
    tick();
    if (HALT_EN) begin
      check("halt_wren", 32'(wr_en),   32'd1);
      check("halt_addr", 32'(wr_addr), 32'd1);
      check("halt_data", 32'(wr_data), 32'h0000);
    end else begin
      check("nohalt_wren", 32'(wr_en), 32'd0);
    end
    wait_done();

    // Reset in the middle of a run, with an op still offered.
    pulse_start();
    send_op(6, 1, 2, 0, 1'b0, 3, acc, a, d);
    send_op(6, 3, 4, 0, 1'b0, 3, acc, a, d);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("mrst_ready", 32'(in_ready), 32'd0);
    check("mrst_wren",  32'(wr_en),    32'd0);
    check("mrst_done",  32'(done),     32'd0);
    check("mrst_addr",  32'(wr_addr),  32'(BASE));
    pulse_start();
    send_op(4, 2, 3, 0, 1'b1, 3, acc, a, d);
    check("mrst_restart_addr", 32'(a), 32'(BASE));
    in_valid = 1'b0;
    wait_done();

    // Randomized programs: bubbles, stray starts, occasional reset.
    for (int p = 0; p < 40; p++) begin
      int len;
      in_valid = 1'($urandom_range(0, 1));
      pulse_start();
      len = $urandom_range(1, 10);
      for (int k = 0; k < len; k++) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
        if ($urandom_range(0, 15) == 0) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          break;
        end
        start = ($urandom_range(0, 7) == 0);
        send_op($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 255), k == len - 1, 3, acc, a, d);
        start = 1'b0;
        if (!acc) break;
      end
      in_valid = 1'b0;
      repeat (2) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/my_encoder.md
Name: my_encoder

Overview:
- Instruction encoder and program loader for the 16-bit core; the inverse of the instruction decoder.
- Accepts symbolic ALU/ADD/ADDI operations over a valid/ready handshake and packs each into a 16-bit instruction word.
- Writes the words to consecutive instruction-memory addresses, starting at BASE.
- Used by the bench and by boot logic to fill instruction memory before the core runs.

Parameters:
- AW, 8, instruction-memory address width.
- BASE, 0, first write address; width AW.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  one-cycle pulse; begins a load run; ignored unless in IDLE or DONE.
- in_valid  in  1  operation present.
- in_ready  out  1  block can accept an operation this cycle.
- in_op  in  3  0 NOT, 1 OR, 2 XOR, 3 AND, 4 FAS, 5 SUB, 6 ADD, 7 ADDI.
- in_ra  in  4  first register field.
- in_rb  in  4  second register field.
- in_imm  in  8  immediate (ADDI only).
- in_last  in  1  marks the final operation of the program.
- wr_en  out  1  instruction-memory write strobe.
- wr_addr  out  AW  write address.
- wr_data  out  16  encoded word.
- busy  out  1  state is RUN or HALT_WR.
- done  out  1  run complete; held until next start or rst.
- err  out  1  sticky; set on memory overflow; cleared by start or rst.

Behaviour:
- Encoding:
  - ALU ops (0–5): {4'b0101, ra, rb, func}. func values: NOT 0000, OR 0001, XOR 0010, AND 0011, FAS 0100, SUB 1000.
  - ADD: {4'b1110, ra, rb, 4'b0000}.
  - ADDI: {4'b1100, ra, imm}.
- Unused input fields are ignored: in_rb for ADDI, in_imm for all non-ADDI ops.
- Transfer occurs when in_valid && in_ready.
- Latency: wr_en, wr_addr and wr_data are registered and appear exactly 1 cycle after the transfer. Throughput is 1 op per cycle.
- Address counter:
  - Loads BASE on start.
  - Increments after each write.
  - wr_addr holds its value while wr_en=0.
- FSM states: IDLE, RUN, HALT_WR, DONE.
  - IDLE/DONE: in_ready=0. start -> RUN, counter=BASE, done=0, err=0.
  - RUN: in_ready=1.
    - Transfer with in_last=1 -> DONE (or HALT_WR when the feature is on).
    - Transfer writing address 2^AW-1 with in_last=0 -> DONE, err=1. The memory-full condition ends the run.
    - Transfer writing address 2^AW-1 with in_last=1 -> DONE, err=0.
  - HALT_WR: exists only with the feature; see Optional Feature.
- in_valid while in_ready=0: no transfer. The source must hold the operation until ready.
- start while in RUN/HALT_WR: ignored.
- start coincident with in_valid in IDLE: no transfer that cycle. in_ready rises the following cycle.
- Reset values: state IDLE; in_ready=0, wr_en=0, wr_addr=BASE, wr_data=0, busy=0, done=0, err=0.
- Reset mid-run: returns to IDLE next edge; no write is issued. Words already written stay in memory.

Optional Feature:
- Macro: MY_ENCODER_HALT_EN.
- Defined:
  - After the in_last transfer, FSM enters HALT_WR (in_ready=0).
  - HALT_WR writes 16'h0000 (HALT) at the next address, then goes to DONE.
  - If in_last landed on address 2^AW-1, no HALT is written; DONE with err=1.
- Undefined: HALT_WR does not exist; in_last goes straight to DONE.

Decomposition:
- Shared package my_isa_pkg holds:
  - Class-nibble constants: CLS_ALU=4'b0101, CLS_ADD=4'b1110, CLS_ADDI=4'b1100.
  - func constants (FN_NOT, FN_OR, FN_XOR, FN_AND, FN_FAS, FN_SUB).
  - Op enum op_e (3-bit).
  - HALT_WORD.
- The decoder is to be migrated to the same package.
- One sub-module: my_encode_word, a pure combinational op/fields -> 16-bit word packer. FSM, counter and output register stay in my_encoder.

Test Plan:
- Reset with AW=4, then start; send SUB ra=1 rb=2, last=1 -> one cycle later wr_en=1, wr_addr=0, wr_data=16'h5128; then done=1, busy=0, err=0.
- Back-to-back ADD ra=3 rb=4, ADDI ra=2 imm=8'hFF, AND ra=0 rb=0 (last) -> writes 16'hE340 @0, 16'hC2FF @1, 16'h5003 @2 on consecutive cycles.
- AW=2: send 5 ops without last -> 4 writes @0–3; after the 4th transfer in_ready=0, done=1, err=1; 5th op is never accepted.
- Hold in_valid low for 3 cycles mid-run -> wr_en=0 for those cycles; wr_addr unchanged.
- Assert rst while in RUN after 2 writes -> next cycle in_ready=0, wr_en=0, done=0, wr_addr=BASE; a later start restarts at BASE.
- With MY_ENCODER_HALT_EN: NOT ra=5 (last) -> 16'h5500 @0, then 16'h0000 @1, then done=1. Without the macro, only the @0 write occurs.
